// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: counts outstanding writes per architectural
// register and stalls decode when a source is pending or a destination counter is full.
module reg_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   A1,
    input  logic [ADDR_W-1:0]   A2,
    input  logic                use1,
    input  logic                use2,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_wr,
    input  logic                WE3,
    input  logic [ADDR_W-1:0]   A3,
    input  logic                flush,
    output logic                stall,
    output logic                issue_ack,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic                           src1_blk;
    logic                           src2_blk;
    logic                           dst_full;
    logic                           inc_any;
    logic                           underflow_hit;
    logic                           underflow_reg;

    // A reader is released early only when this cycle's retirement drains the last write.
    function automatic logic blocked(input logic [CNT_W-1:0] c, input logic retire);
        logic b;
        b = (c != '0);
        if (WB_BYPASS != 0)
            b = b & ~(retire & (c == CNT_ONE));
        return b;
    endfunction

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    always_comb begin
        src1_blk  = use1 && (A1 != '0) && blocked(cnt[A1], WE3 && (A3 == A1));
        src2_blk  = use2 && (A2 != '0) && blocked(cnt[A2], WE3 && (A3 == A2));
        dst_full  = issue_wr && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
        stall     = issue_valid && (src1_blk || src2_blk || dst_full);
        issue_ack = issue_valid && !stall;
        inc_any   = issue_ack && issue_wr && (issue_rd != '0);
        underflow_hit = WE3 && (A3 != '0) && (cnt[A3] == '0)
                        && !(inc_any && (issue_rd == A3));
    end

    always_ff @(posedge clk) begin
        if (reset)
            underflow_reg <= 1'b0;
        else if (!flush && underflow_hit)
            underflow_reg <= 1'b1;
    end

    assign underflow_err = underflow_reg;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic             inc;
            logic             dec;

            assign inc = inc_any && (issue_rd == ADDR_W'(gi));
            assign dec = WE3 && (A3 == ADDR_W'(gi)) && (cnt_reg != '0);

            // Stall prevents inc at CNT_MAX, and dec requires a nonzero count, so no wrap.
            always_ff @(posedge clk) begin
                if (reset || flush)
                    cnt_reg <= '0;
                else if (inc && !dec)
                    cnt_reg <= cnt_reg + CNT_ONE;
                else if (dec && !inc)
                    cnt_reg <= cnt_reg - CNT_ONE;
            end

            assign cnt[gi]       = cnt_reg;
            assign busy_mask[gi] = (cnt_reg != '0);
        end
    endgenerate

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard: combinational stall/ack are checked before
// each edge, post-edge busy_mask/underflow_err are queued and compared after the edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [4:0]  A1, A2, issue_rd, A3;
    logic        use1, use2, issue_valid, issue_wr, WE3;
    logic        stall, issue_ack, underflow_err;
    logic [31:0] busy_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .use1(use1), .use2(use2),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
        .WE3(WE3), .A3(A3), .flush(flush), .stall(stall), .issue_ack(issue_ack),
        .busy_mask(busy_mask), .underflow_err(underflow_err)
    );

    typedef struct {
        logic        rst, fl;
        logic [4:0]  a1;
        logic        u1;
        logic [4:0]  a2;
        logic        u2, iv;
        logic [4:0]  rd;
        logic        wr, we3;
        logic [4:0]  a3;
        logic        es, ea;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    typedef struct {
        logic [31:0] busy;
        logic        err;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(input logic rst, input logic fl,
                               input logic [4:0] a1, input logic u1,
                               input logic [4:0] a2, input logic u2,
                               input logic iv, input logic [4:0] rd, input logic wr,
                               input logic we3, input logic [4:0] a3,
                               input logic es, input logic ea,
                               input logic [31:0] eb, input logic ee);
        vec_t t;
        t.rst = rst; t.fl = fl; t.a1 = a1; t.u1 = u1; t.a2 = a2; t.u2 = u2;
        t.iv = iv; t.rd = rd; t.wr = wr; t.we3 = we3; t.a3 = a3;
        t.es = es; t.ea = ea; t.eb = eb; t.ee = ee;
        return t;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        reset = t.rst; flush = t.fl;
        A1 = t.a1; use1 = t.u1; A2 = t.a2; use2 = t.u2;
        issue_valid = t.iv; issue_rd = t.rd; issue_wr = t.wr;
        WE3 = t.we3; A3 = t.a3;
        #2;
        check("stall", idx, {31'b0, stall}, {31'b0, t.es});
        check("issue_ack", idx, {31'b0, issue_ack}, {31'b0, t.ea});
        sb.push_back('{busy: t.eb, err: t.ee, idx: idx});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("busy_mask", e.idx, busy_mask, e.busy);
        check("underflow_err", e.idx, {31'b0, underflow_err}, {31'b0, e.err});
        $display("vec %0d: stall=%b ack=%b busy_mask=%h underflow_err=%b",
                 idx, stall, issue_ack, busy_mask, underflow_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst fl a1 u1 a2 u2 iv rd wr we a3   es ea busy          err
        tbl.push_back(v(0,0, 5,0, 0,0, 1, 5,1, 0,0,  0,1, 32'h0000_0020, 0)); // issue x5
        tbl.push_back(v(0,0, 5,1, 0,0, 1, 0,0, 0,0,  1,0, 32'h0000_0020, 0)); // read x5 pending
        tbl.push_back(v(0,0, 5,1, 0,0, 1, 0,0, 1,5,  0,1, 32'h0000_0000, 0)); // bypass on retire
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 7,1, 0,0,  0,1, 32'h0000_0080, 0));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 7,1, 0,0,  0,1, 32'h0000_0080, 0));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 7,1, 0,0,  0,1, 32'h0000_0080, 0)); // cnt7=3
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 7,1, 0,0,  1,0, 32'h0000_0080, 0)); // counter full
        tbl.push_back(v(0,0, 0,0, 0,0, 0, 0,0, 1,7,  0,0, 32'h0000_0080, 0)); // cnt7=2
        tbl.push_back(v(0,0, 0,0, 7,1, 1, 0,0, 1,7,  1,0, 32'h0000_0080, 0)); // no bypass at 2
        tbl.push_back(v(0,0, 0,0, 7,1, 1, 0,0, 1,7,  0,1, 32'h0000_0000, 0)); // bypass at 1
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 0,1, 0,0,  0,1, 32'h0000_0000, 0)); // issue x0
        tbl.push_back(v(0,0, 0,1, 0,0, 1, 0,0, 0,0,  0,1, 32'h0000_0000, 0)); // read x0
        tbl.push_back(v(0,0, 0,0, 0,0, 0, 0,0, 1,0,  0,0, 32'h0000_0000, 0)); // retire x0
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 9,1, 0,0,  0,1, 32'h0000_0200, 0));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 9,1, 1,9,  0,1, 32'h0000_0200, 0)); // inc+dec
        tbl.push_back(v(0,0, 0,0, 0,0, 0, 0,0, 1,12, 0,0, 32'h0000_0200, 1)); // underflow
        tbl.push_back(v(0,0, 0,0, 0,0, 0, 0,0, 0,0,  0,0, 32'h0000_0200, 1)); // sticky
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 3,1, 0,0,  0,1, 32'h0000_0208, 1));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 4,1, 0,0,  0,1, 32'h0000_0218, 1));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 8,1, 0,0,  0,1, 32'h0000_0318, 1));
        tbl.push_back(v(0,1, 0,0, 0,0, 1,10,1, 0,0,  0,1, 32'h0000_0000, 1)); // flush
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 3,1, 0,0,  0,1, 32'h0000_0008, 1));
        tbl.push_back(v(0,0, 0,0, 0,0, 1, 4,1, 0,0,  0,1, 32'h0000_0018, 1));
        tbl.push_back(v(0,0, 3,0, 0,0, 1, 0,0, 0,0,  0,1, 32'h0000_0018, 1)); // use1=0
        tbl.push_back(v(0,0, 0,0, 4,1, 1, 0,0, 0,0,  1,0, 32'h0000_0018, 1)); // src2 pending
        tbl.push_back(v(1,0, 3,1, 0,0, 1, 0,0, 0,0,  1,0, 32'h0000_0000, 0)); // reset mid-op
        tbl.push_back(v(0,0, 3,1, 4,1, 1, 0,0, 0,0,  0,1, 32'h0000_0000, 0));

        apply(v(1,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0, 32'h0, 0), 0);

        // Sweep every source pair on an empty scoreboard.
        for (int i = 0; i < 32; i++) begin
            vec_t s;
            s = v(0,0, 5'(i),1, 5'(31 - i),1, 1, 0,0, 0,0, 0,1, 32'h0, 0);
            apply(s, 100 + i);
        end

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], 200 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
